vacuum_cycle_sequencer: RTL and testbench

// Sequencer that drives the command inputs of the vacuum Moore FSM (power_off/on/cleaning/evading).

---
 rtl/vacuum_cycle_sequencer_if.sv | 23 ++
 rtl/vacuum_cycle_sequencer.sv | 175 +++++++++++++++++
 tb/tb_vacuum_cycle_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vacuum_cycle_sequencer_if.sv
// Switch inputs and FSM command outputs of the vacuum cycle sequencer.
// The master side drives the raw switches; the slave side is the sequencer.
interface vacuum_cycle_sequencer_if;
    logic       pwr_btn;
    logic       clean_btn;
    logic       bumper;
    logic       battery_low;
    logic [3:0] cmd;
    logic [2:0] state;
    logic [1:0] evade_cnt;
    logic       done;
    logic       fault;

    modport master (
        output pwr_btn, clean_btn, bumper, battery_low,
        input  cmd, state, evade_cnt, done, fault
    );

    modport slave (
        input  pwr_btn, clean_btn, bumper, battery_low,
        output cmd, state, evade_cnt, done, fault
    );
endinterface

// File: rtl/vacuum_cycle_sequencer.sv
// Timed cleaning-cycle sequencer that produces one-hot commands for the vacuum FSM.
// Handles input synchronisation, bumper debounce, evade manoeuvres and fault escalation.
module vacuum_cycle_sequencer #(
    parameter int CLEAN_CYCLES    = 1000,
    parameter int EVADE_CYCLES    = 50,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_EVADES      = 3
) (
    input logic                      clk,
    input logic                      rst,
    vacuum_cycle_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_IDLE  = 3'd1,
        S_CLEAN = 3'd2,
        S_EVADE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int CW = $clog2(CLEAN_CYCLES);
    localparam int EW = $clog2(EVADE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] MAX_CNT = 2'(MAX_EVADES);

    // bit order in the sync chain: {battery_low, bumper, clean_btn, pwr_btn}
    logic [3:0] s_meta, s_sync, s_lvl;
    logic [1:0] s_prev;
    logic       pwr_pulse, clean_pulse;
    logic       bump_db;
    logic [DW-1:0] db_cnt;

    logic          bat;
    state_t        state_q, state_d;
    logic [CW-1:0] ctmr_q, ctmr_d;
    logic [EW-1:0] etmr_q, etmr_d;
    logic [1:0]    cnt_q, cnt_d, cnt_inc;
    logic          done_q, done_d;
    logic [3:0]    cmd;
    logic          fault;

    // Extra level stage after the 2-flop synchroniser keeps button-to-state latency at four edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta      <= '0;
            s_sync      <= '0;
            s_lvl       <= '0;
            s_prev      <= '0;
            pwr_pulse   <= 1'b0;
            clean_pulse <= 1'b0;
        end else begin
            s_meta      <= {bus.battery_low, bus.bumper, bus.clean_btn, bus.pwr_btn};
            s_sync      <= s_meta;
            s_lvl       <= s_sync;
            s_prev      <= s_lvl[1:0];
            pwr_pulse   <= s_lvl[0] & ~s_prev[0];
            clean_pulse <= s_lvl[1] & ~s_prev[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bump_db <= 1'b0;
            db_cnt  <= '0;
        end else if (s_lvl[2] != bump_db) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                bump_db <= s_lvl[2];
                db_cnt  <= '0;
            end else begin
                db_cnt  <= db_cnt + DW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign bat     = s_lvl[3];
    assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
            ctmr_q  <= '0;
            etmr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctmr_q  <= ctmr_d;
            etmr_q  <= etmr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctmr_d  = ctmr_q;
        etmr_d  = etmr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_OFF: if (pwr_pulse) state_d = S_IDLE;
            S_IDLE: begin
                if (pwr_pulse) begin
                    state_d = S_OFF;
                end else if (clean_pulse && !bat) begin
                    state_d = S_CLEAN;
                    ctmr_d  = CW'(CLEAN_CYCLES - 1);
                    cnt_d   = '0;
                end
            end
            S_CLEAN: begin
                if (pwr_pulse) begin
                    state_d = S_OFF;
                end else if (bat) begin
                    state_d = S_IDLE;
                end else if (ctmr_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ctmr_d = ctmr_q - CW'(1);
                    if (bump_db) begin
                        state_d = S_EVADE;
                        etmr_d  = EW'(EVADE_CYCLES - 1);
                        cnt_d   = cnt_inc;
                    end
                end
            end
            S_EVADE: begin
                if (pwr_pulse) begin
                    state_d = S_OFF;
                end else if (bat) begin
                    state_d = S_IDLE;
                end else if (etmr_q == '0) begin
                    if (cnt_q == MAX_CNT) begin
                        state_d = S_FAULT;
                    end else if (bump_db) begin
                        etmr_d = EW'(EVADE_CYCLES - 1);
                        cnt_d  = cnt_inc;
                    end else begin
                        state_d = S_CLEAN;
                    end
                end else begin
                    etmr_d = etmr_q - EW'(1);
                end
            end
            S_FAULT: if (pwr_pulse) state_d = S_OFF;
            default: state_d = S_OFF;
        endcase
        if (state_d == S_OFF) begin
            ctmr_d = '0;
            etmr_d = '0;
            cnt_d  = '0;
        end
    end

    always_comb begin
        cmd   = 4'b0001;
        fault = 1'b0;
        case (state_q)
            S_IDLE:  cmd   = 4'b0010;
            S_CLEAN: cmd   = 4'b0100;
            S_EVADE: cmd   = 4'b1000;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign bus.cmd       = cmd;
    assign bus.state     = state_q;
    assign bus.evade_cnt = cnt_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault;
endmodule

// File: tb/tb_vacuum_cycle_sequencer.sv
// Randomised bench for the vacuum cycle sequencer with a cycle-level reference model
// and a scoreboard of expected state/evade_cnt/done events.
module tb_vacuum_cycle_sequencer;
    localparam int C = 20, E = 5, D = 2, M = 3, HN = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   checks = 0, errors = 0;

    vacuum_cycle_sequencer_if vif();

    vacuum_cycle_sequencer #(
        .CLEAN_CYCLES(C), .EVADE_CYCLES(E), .DEBOUNCE_CYCLES(D), .MAX_EVADES(M)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int st;
        int cnt;
        bit done;
    } ev_t;
    ev_t sb[$];

    // raw input histories, index = edge before which the value was applied
    bit p_h[HN], c_h[HN], b_h[HN], t_h[HN];

    // reference model: served/elapsed count up; states are 0 OFF 1 IDLE 2 CLEAN 3 EVADE 4 FAULT
    int m_state, m_cnt, m_served, m_elapsed, m_run;
    bit m_db;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic bit raw(int w, int i);
        if (i < 1 || i >= HN) return 1'b0;
        case (w)
            0: return p_h[i];
            1: return c_h[i];
            2: return b_h[i];
            default: return t_h[i];
        endcase
    endfunction

    function automatic logic [3:0] exp_cmd(int s);
        case (s)
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic model_step(int e);
        bit pwr, cln, bat, dn, s;
        int ps, pc;
        ev_t ev;
        pwr = raw(0, e - 4) & ~raw(0, e - 5);
        cln = raw(1, e - 4) & ~raw(1, e - 5);
        bat = raw(3, e - 3);
        dn  = 1'b0;
        ps  = m_state;
        pc  = m_cnt;
        case (m_state)
            0: if (pwr) m_state = 1;
            1: if (pwr) begin m_state = 0; m_cnt = 0; end
               else if (cln && !bat) begin m_state = 2; m_served = 0; m_cnt = 0; end
            2: if (pwr) begin m_state = 0; m_cnt = 0; end
               else if (bat) m_state = 1;
               else if (m_served == C - 1) begin m_state = 1; dn = 1'b1; end
               else begin
                   m_served++;
                   if (m_db) begin
                       m_state = 3; m_elapsed = 0;
                       if (m_cnt < M) m_cnt++;
                   end
               end
            3: if (pwr) begin m_state = 0; m_cnt = 0; end
               else if (bat) m_state = 1;
               else if (m_elapsed == E - 1) begin
                   if (m_cnt == M) m_state = 4;
                   else if (m_db) begin m_elapsed = 0; if (m_cnt < M) m_cnt++; end
                   else m_state = 2;
               end else m_elapsed++;
            default: if (pwr) begin m_state = 0; m_cnt = 0; end
        endcase
        // bumper debounce sees the synced level of this edge; takes effect next edge
        s = raw(2, e - 3);
        if (s != m_db) begin
            m_run++;
            if (m_run == D) begin m_db = s; m_run = 0; end
        end else m_run = 0;
        if (ps != m_state || pc != m_cnt || dn) begin
            ev.cyc = e; ev.st = m_state; ev.cnt = m_cnt; ev.done = dn;
            sb.push_back(ev);
        end
    endtask

    task automatic drive(bit p, bit c, bit b, bit t, int n);
        for (int i = 0; i < n; i++) begin
            vif.pwr_btn = p; vif.clean_btn = c; vif.bumper = b; vif.battery_low = t;
            if (cyc + 1 < HN) begin
                p_h[cyc+1] = p; c_h[cyc+1] = c; b_h[cyc+1] = b; t_h[cyc+1] = t;
            end
            @(posedge clk);
            #1;
            model_step(cyc);
        end
    endtask

    task automatic press(bit pwr);
        drive(pwr, !pwr, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        vif.pwr_btn = 1'b0; vif.clean_btn = 1'b0; vif.bumper = 1'b0; vif.battery_low = 1'b0;
        #1;
        chk("rst_state", vif.state, 0);
        chk("rst_cmd", vif.cmd, 1);
        chk("rst_evade_cnt", vif.evade_cnt, 0);
        chk("rst_done", vif.done, 0);
        chk("rst_fault", vif.fault, 0);
        chk("rst_pending_events", sb.size(), 0);
        sb.delete();
        for (int i = 0; i < HN; i++) begin
            p_h[i] = 1'b0; c_h[i] = 1'b0; b_h[i] = 1'b0; t_h[i] = 1'b0;
        end
        m_state = 0; m_cnt = 0; m_served = 0; m_elapsed = 0; m_run = 0; m_db = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic bump_until_evade();
        int n = 0;
        while (m_state != 3 && n < 100) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
            n++;
        end
        if (m_state != 3) flag_fail("evade_wait_timeout");
    endtask

    // monitor: the DUT presents an event whenever state/evade_cnt change or done pulses
    int exp_st, prev_st, prev_cnt;
    ev_t mev;
    always @(negedge clk) begin
        if (rst) begin
            exp_st = 0; prev_st = 0; prev_cnt = 0;
        end else begin
            if (int'(vif.state) != prev_st || int'(vif.evade_cnt) != prev_cnt || vif.done) begin
                if (sb.size() == 0) flag_fail("unexpected_event");
                else begin
                    mev = sb.pop_front();
                    chk("event_cycle", cyc, mev.cyc);
                    chk("state", vif.state, mev.st);
                    chk("evade_cnt", vif.evade_cnt, mev.cnt);
                    chk("done", vif.done, mev.done);
                    exp_st = mev.st;
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mev = sb.pop_front();
                flag_fail("missed_event");
                exp_st = mev.st;
            end
            chk("cmd", vif.cmd, exp_cmd(exp_st));
            chk("fault", vif.fault, exp_st == 4);
            prev_st = vif.state;
            prev_cnt = vif.evade_cnt;
        end
    end

    initial begin
        int a;
        do_reset();
        // power on, then one uninterrupted cycle ending in done
        press(1'b1);
        press(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 25);
        // short bumper hit mid-cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40);
        // bumper held: evade escalation to fault, clean ignored, pwr clears
        press(1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 60);
        press(1'b0);
        press(1'b1);
        // battery_low during evade, then clean refused while battery_low
        press(1'b1);
        press(1'b0);
        bump_until_evade();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5);
        // one-cycle bumper glitch, then power off mid-clean
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
        press(1'b1);
        // reset while evading
        press(1'b1);
        press(1'b0);
        bump_until_evade();
        do_reset();
        // randomised traffic
        while (cyc < 4000) begin
            a = $urandom_range(0, 99);
            if (m_state == 0 && $urandom_range(0, 3) == 0) a = 0;
            if (a < 2)       press(1'b1);
            else if (a < 8)  press(1'b0);
            else if (a < 14) drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(1, 25));
            else if (a < 16) drive(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(1, 15));
            else if (a < 17) drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom_range(1, 10));
            else             drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
